// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Handshake and data bundle between a controller and serial_subtractor.
//   master modport: controller side (drives start/A/B/Bin, observes results).
//   slave  modport: subtractor side (observes request, drives results/status).
//   Signals:
//     start  request, sampled by the subtractor only when it is not busy
//     A, B   minuend / subtrahend, WIDTH bits
//     Bin    borrow-in
//     Diff   A - B - Bin modulo 2^WIDTH
//     Bout   unsigned borrow-out
//     V      signed overflow
//     busy   operation in progress
//     done   one-cycle pulse when Diff/Bout/V update
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Bin,
    input  Diff, Bout, V, busy, done
  );

  modport slave (
    input  start, A, B, Bin,
    output Diff, Bout, V, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: Diff = A - B - Bin over WIDTH bits, one bit per
//   clock through a single full-subtractor slice with a borrow flop.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  serial_subtractor_if.slave (start/A/B/Bin in, Diff/Bout/V/busy/done out)
//   Timing: start accepted at edge E0 (when idle or done); bits 0..WIDTH-1 are
//   processed at edges E1..E_WIDTH; results and done appear after E_WIDTH.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;      // captured minuend, shifted right each bit
  logic [WIDTH-1:0] b_sh;      // captured subtrahend, shifted right each bit
  logic             br;        // running borrow
  logic [CNT_W-1:0] cnt;       // index of the bit being processed
  logic [WIDTH-2:0] r_sh;      // partial result, filled from the top LSB-first
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             v_q;

  // Full-subtractor slice on the current LSBs.
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] r_next;

  assign a_bit   = a_sh[0];
  assign b_bit   = b_sh[0];
  assign d_bit   = a_bit ^ b_bit ^ br;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  // On the last bit this is the complete difference, bit 0 at the bottom.
  assign r_next  = {d_bit, r_sh};

  // NOTE: every flop in the datapath is cleared by reset, including the
  // operand and partial-result shift registers, so an aborted operation
  // leaves nothing behind; all state is updated with non-blocking
  // assignments so the slice reads the pre-edge values of a_sh/b_sh/br.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      r_sh   <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_sh  <= bus.A;
            b_sh  <= bus.B;
            br    <= bus.Bin;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          r_sh <= r_next[WIDTH-1:1];
          if (cnt == CNT_LAST) begin
            // On the last bit a_bit/b_bit are the operand sign bits.
            diff_q <= r_next;
            bout_q <= br_next;
            v_q    <= (a_bit ^ b_bit) & (d_bit ^ a_bit);
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.V    = v_q;
  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor (WIDTH=4). The stimulus side pushes
//   an expected result (from a plain-arithmetic model) when an operation is
//   accepted; a monitor pops and compares on every done pulse, checks the
//   completion latency, and checks that the outputs hold between completions.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         v;
    int           due;   // cycle at which done must be seen
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_bad;
  exp_t sb[$];
  logic [W-1:0] hold_diff;
  logic         hold_bout;
  logic         hold_v;
  int           last_accept;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: ordinary wide arithmetic; V from the sign-bit rule.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    int   full;
    full   = int'(a) - int'(b) - int'(bin);
    e.diff = W'(full);
    e.bout = (full < 0);
    e.v    = (a[W-1] ^ b[W-1]) & (e.diff[W-1] ^ a[W-1]);
    e.due  = 0;
    return e;
  endfunction

  // Monitor: compares every done pulse against the scoreboard and checks
  // that results hold steady in all other cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (bus.done === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 32'(bus.done), 32'(0));
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("diff", 32'(bus.Diff), 32'(e.diff));
            check("bout", 32'(bus.Bout), 32'(e.bout));
            check("v",    32'(bus.V),    32'(e.v));
            check("latency_cycle", 32'(cyc), 32'(e.due));
            check("busy_at_done", 32'(bus.busy), 32'(0));
            hold_diff = e.diff;
            hold_bout = e.bout;
            hold_v    = e.v;
          end
        end else begin
          check("hold", 32'({bus.Diff, bus.Bout, bus.V}), 32'({hold_diff, hold_bout, hold_v}));
        end
      end
    end
  end

  // All stimulus tasks start and end #1 after a rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input int gap);
    exp_t e;
    int   guard;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'(guard), 32'(0));
    @(posedge clk); #1;
    e     = model(a, b, bin);
    e.due = cyc + W;
    sb.push_back(e);
    last_accept = cyc;
    check("busy_after_accept", 32'(bus.busy), 32'(1));
    bus.start = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_pending", 32'(sb.size()), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    sb.delete();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    hold_diff = '0;
    hold_bout = 1'b0;
    hold_v    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    n_vec = 0;
    n_bad = 0;
    cyc   = 0;
    hold_diff = '0;
    hold_bout = 1'b0;
    hold_v    = 1'b0;
    last_accept = 0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    rst       = 1'b1;
    #1;

    // Reset then idle.
    apply_reset(2);
    repeat (5) begin
      check("idle_outputs", 32'({bus.Diff, bus.Bout, bus.V}), 32'(0));
      check("idle_busy", 32'(bus.busy), 32'(0));
      check("idle_done", 32'(bus.done), 32'(0));
      @(posedge clk); #1;
    end

    // Directed cases.
    issue(4'd5, 4'd2, 1'b0, 0);
    check("busy_mid_run", 32'(bus.busy), 32'(1));
    drain();
    issue(4'd3, 4'd9, 1'b0, 1);
    issue(4'd7, 4'd8, 1'b0, 0);
    issue(4'd0, 4'd0, 1'b1, 0);
    issue(4'hF, 4'hF, 1'b1, 2);
    drain();

    // start held high: back-to-back every WIDTH+1 cycles.
    issue(4'd8, 4'd1, 1'b0, 0);
    acc0 = last_accept;
    issue(4'd8, 4'd1, 1'b0, 0);
    check("b2b_interval", 32'(last_accept - acc0), 32'(W + 1));
    acc0 = last_accept;
    issue(4'd8, 4'd1, 1'b0, 0);
    check("b2b_interval", 32'(last_accept - acc0), 32'(W + 1));
    drain();

    // start and operand changes during RUN are ignored.
    issue(4'd3, 4'd9, 1'b0, 0);
    bus.A     = 4'hF;
    bus.B     = 4'h0;
    bus.Bin   = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_ignores_start", 32'(bus.busy), 32'(1));
    drain();

    // Reset mid-operation: rst sampled at E2, no done for the aborted op.
    issue(4'd6, 4'd1, 1'b0, 0);
    @(posedge clk); #1;
    apply_reset(1);
    check("abort_outputs", 32'({bus.Diff, bus.Bout, bus.V}), 32'(0));
    check("abort_busy", 32'(bus.busy), 32'(0));
    repeat (W + 2) begin
      check("abort_no_done", 32'(bus.done), 32'(0));
      @(posedge clk); #1;
    end
    issue(4'd6, 4'd1, 1'b0, 0);
    drain();

    // Randomised operations with random gaps (0 gives back-to-back).
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
